// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, word width
// and the address check applied to requests when DMEM_ERR_CHECK_EN is defined.
package dmem_responder_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Misaligned, or any byte-address bit above the word index is set.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned idx_w);
    logic [31:0] upper_mask;
    upper_mask = 32'hFFFF_FFFF << (idx_w + 2);
    return (addr[1:0] != 2'b00) || ((addr & upper_mask) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// Loadable down-counter timing the BUSY phase; done is high while the count is 1.
module dmem_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = (count_reg == W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with one outstanding request and a fixed latency.
// Optional DMEM_ERR_CHECK_EN flags misaligned/out-of-range requests and suppresses their effects.
import dmem_responder_pkg::*;

module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY) + 1;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [WORD_W-1:0] rdata_reg;
  logic              err_reg;
  logic [IDX_W-1:0]  word_idx;
  logic              accept;
  logic              req_err;
  logic              cnt_done;

  assign word_idx = req_addr_i[IDX_W+1:2];
  assign accept   = req_valid_i && (state_reg == ST_IDLE);

`ifdef DMEM_ERR_CHECK_EN
  assign req_err = addr_err(req_addr_i, IDX_W);
`else
  // Without checking, the offset and upper bits are don't-care and addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr_i[31:IDX_W+2], req_addr_i[1:0]};
  assign req_err = 1'b0;
`endif

  dmem_lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .load     (accept && (LATENCY > 1)),
    .dec      (state_reg == ST_BUSY),
    .load_val (CNT_W'(LATENCY - 1)),
    .done     (cnt_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (cnt_done) state_next = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rdata_reg <= (req_write_i || req_err) ? '0 : mem[word_idx];
        err_reg   <= req_err;
      end else if ((state_reg == ST_RESP) && rsp_ready_i) begin
        rdata_reg <= '0;
        err_reg   <= 1'b0;
      end
    end
  end

  // The array is deliberately outside reset so a committed store survives it.
  always_ff @(posedge clk_i) begin
    if (accept && req_write_i && !req_err) begin
      mem[word_idx] <= req_wdata_i;
    end
  end

  assign req_ready_o = (state_reg == ST_IDLE);
  assign rsp_valid_o = (state_reg == ST_RESP);
  assign rsp_rdata_o = rdata_reg;
  assign rsp_err_o   = err_reg;

endmodule
